// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch
//  Purpose  : Fetch stage. Holds the PC, reads the instruction ROM
//             combinationally, redirects on taken branches and freezes in a
//             sticky fault state when the next PC would be illegal.
//  Revision : 1.0  initial release
// ============================================================================
module instr_fetch #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          ROM_ADDR_BITS = 8,
  parameter string       ROM_FILE      = "program.mem"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        PCsrc,
  input  logic [31:0] ImmOp,
  output logic [31:0] PC,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        fault
);

  localparam logic [31:0] C_NOP       = 32'h0000_0013;
  localparam int          C_ROM_DEPTH = 2 ** ROM_ADDR_BITS;
  // One past the last legal byte address; 33 bits so large ROMs cannot wrap.
  localparam logic [32:0] C_ROM_BYTES = 33'(4) << ROM_ADDR_BITS;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  logic [31:0] rom [0:C_ROM_DEPTH-1];

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        fault_q, fault_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] next_pc;
  logic        next_legal;

  // Next-state logic; PCsrc/ImmOp only influence registered state, never instr.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_d    = fault_q;
    next_pc    = PCsrc ? (pc_q + ImmOp) : (pc_q + 32'd4);
    next_legal = (next_pc[1:0] == 2'b00) && ({1'b0, next_pc} < C_ROM_BYTES);
    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (!stall) begin
          if (next_legal) begin
            pc_d = next_pc;
          end else begin
            fault_d = 1'b1;
            state_d = ST_HALT;
          end
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: begin
        fault_d = 1'b1;
        state_d = ST_HALT;
      end
    endcase
    instr_valid_d = (state_d == ST_RUN);
  end

  // State, PC and registered status outputs; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      fault_q       <= 1'b0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fault_q       <= fault_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  // PC must stay word aligned at all times.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (pc_q[1:0] == 2'b00);
    end
  end

  assign PC          = pc_q;
  assign fault       = fault_q;
  assign instr_valid = instr_valid_q;
  assign instr       = (state_q == ST_RUN) ? rom[pc_q[ROM_ADDR_BITS+1:2]] : C_NOP;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch
//  Purpose  : Directed self-checking bench for instr_fetch.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instr_fetch;

  localparam logic [31:0] C_NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        PCsrc;
  logic [31:0] ImmOp;
  logic [31:0] PC;
  logic [31:0] instr;
  logic        instr_valid;
  logic        fault;

  int n_checks = 0;
  int n_pass   = 0;

  instr_fetch #(
    .RESET_PC      (32'h0000_0000),
    .ROM_ADDR_BITS (8),
    .ROM_FILE      ("")
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .PCsrc       (PCsrc),
    .ImmOp       (ImmOp),
    .PC          (PC),
    .instr       (instr),
    .instr_valid (instr_valid),
    .fault       (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {8'hA5, b, ~b, 8'h5A};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Check the whole visible state in one call.
  task automatic chk_all(input string tag, input logic [31:0] e_pc,
                         input logic [31:0] e_instr, input logic e_valid,
                         input logic e_fault);
    chk({tag, ".pc"},    PC,                  e_pc);
    chk({tag, ".instr"}, instr,               e_instr);
    chk({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, e_valid});
    chk({tag, ".fault"}, {31'd0, fault},       {31'd0, e_fault});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst   = 1'b1;
    stall = 1'b0;
    PCsrc = 1'b0;
    ImmOp = 32'd0;
    for (int i = 0; i < 256; i++) dut.rom[i] = rom_word(i);

    // Reset and the BOOT cycle
    tick();
    tick();
    chk_all("reset", 32'd0, C_NOP, 1'b0, 1'b0);
    rst = 1'b0;

    // Sequential fetch 0,4,8,12
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_all($sformatf("seq%0d", i), 32'(4 * i), rom_word(i), 1'b1, 1'b0);
    end

    // Backward branch from 12 to 8, then -8 from 8 to 0
    PCsrc = 1'b1; ImmOp = 32'hFFFF_FFFC;
    tick(); chk_all("br_m4", 32'd8, rom_word(2), 1'b1, 1'b0);
    ImmOp = 32'hFFFF_FFF8;
    tick(); chk_all("br_m8", 32'd0, rom_word(0), 1'b1, 1'b0);
    PCsrc = 1'b0;
    tick(); chk("seq_a.pc", PC, 32'd4);
    tick(); chk("seq_b.pc", PC, 32'd8);
    PCsrc = 1'b1; ImmOp = 32'd16;
    tick(); chk_all("br_p16", 32'd24, rom_word(6), 1'b1, 1'b0);
    ImmOp = 32'hFFFF_FFF4;
    tick(); chk_all("br_m12", 32'd12, rom_word(3), 1'b1, 1'b0);

    // Stall beats a pending branch for three cycles
    stall = 1'b1; PCsrc = 1'b1; ImmOp = 32'd16;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all($sformatf("stall%0d", i), 32'd12, rom_word(3), 1'b1, 1'b0);
    end
    stall = 1'b0;
    tick(); chk_all("post_stall", 32'd28, rom_word(7), 1'b1, 1'b0);

    // Misaligned target from PC=4 faults and freezes
    ImmOp = 32'hFFFF_FFE8;
    tick(); chk("to4.pc", PC, 32'd4);
    ImmOp = 32'd2;
    tick(); chk_all("misalign", 32'd4, C_NOP, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      stall = 1'($urandom);
      PCsrc = 1'($urandom);
      ImmOp = {$urandom} & 32'hFFFF_FFFC;
      tick();
      chk_all($sformatf("halt%0d", i), 32'd4, C_NOP, 1'b0, 1'b1);
    end

    // Reset out of HALT, then run sequentially to the last word
    rst = 1'b1; stall = 1'b0; PCsrc = 1'b0; ImmOp = 32'd0;
    tick(); chk_all("rst_halt", 32'd0, C_NOP, 1'b0, 1'b0);
    rst = 1'b0;
    tick(); chk_all("boot_run", 32'd0, rom_word(0), 1'b1, 1'b0);
    repeat (255) tick();
    chk_all("last_word", 32'd1020, rom_word(255), 1'b1, 1'b0);
    tick(); chk_all("past_end", 32'd1020, C_NOP, 1'b0, 1'b1);
    rst = 1'b1;
    tick(); chk_all("rst_end", 32'd0, C_NOP, 1'b0, 1'b0);
    rst = 1'b0;
    tick(); chk_all("run_end", 32'd0, rom_word(0), 1'b1, 1'b0);

    // Reset mid-run wins over a branch
    PCsrc = 1'b1; ImmOp = 32'd40;
    tick(); chk_all("to40", 32'd40, rom_word(10), 1'b1, 1'b0);
    rst = 1'b1;
    tick(); chk_all("rst_run", 32'd0, C_NOP, 1'b0, 1'b0);
    rst = 1'b0; PCsrc = 1'b0;
    tick(); chk_all("rst_run1", 32'd0, rom_word(0), 1'b1, 1'b0);
    tick(); chk_all("rst_run2", 32'd4, rom_word(1), 1'b1, 1'b0);

    // Negative offset wrapping below zero faults
    PCsrc = 1'b1; ImmOp = 32'hFFFF_FFF8;
    tick(); chk_all("wrap_neg", 32'd4, C_NOP, 1'b0, 1'b1);

    // Out-of-range forward branch faults
    rst = 1'b1; PCsrc = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    PCsrc = 1'b1; ImmOp = 32'd1024;
    tick(); chk_all("oor", 32'd0, C_NOP, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
